// File: rtl/subleq_ctrl.sv
// Sequencer for the subleq core: fetches A/B/C, computes mem[B]-mem[A], writes it back
// to mem[B], then branches to C (or halts) when the result is signed <= 0.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module subleq_ctrl #(
  parameter int                   WORD_SIZE = `WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] HALT_ADDR = '1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 run,
  input  logic [WORD_SIZE-1:0] pc_in,
  output logic                 branch,
  output logic                 inc,
  output logic [WORD_SIZE-1:0] branch_addr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 halted
);

  typedef enum logic [3:0] {
    IDLE, FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, STORE, UPDATE, HALT
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] op_a_q, op_a_d;
  logic [WORD_SIZE-1:0] op_b_q, op_b_d;
  logic [WORD_SIZE-1:0] op_c_q, op_c_d;
  logic [WORD_SIZE-1:0] val_a_q, val_a_d;
  logic [WORD_SIZE-1:0] diff_q, diff_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic                 branch_q, branch_d;
  logic                 halted_q, halted_d;

  logic                 ack;
  logic                 leq;
  logic                 take_halt;
  logic [WORD_SIZE-1:0] load_diff;
  logic [WORD_SIZE-1:0] pc_next;

  // An ack only counts while our own request is outstanding.
  assign ack       = mem_req_q & mem_ack;
  assign leq       = (diff_q == '0) | diff_q[WORD_SIZE-1];
  assign take_halt = leq & (op_c_q == HALT_ADDR);
  assign load_diff = mem_rdata - val_a_q;
  // The PC increments on the same edge that completes a fetch, so the following
  // fetch address must already be pc+1 when it is registered.
  assign pc_next   = pc_in + WORD_SIZE'(1);

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= '0;
      val_a_q     <= '0;
      diff_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      branch_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
      val_a_q     <= val_a_d;
      diff_q      <= diff_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      branch_q    <= branch_d;
      halted_q    <= halted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_c_d      = op_c_q;
    val_a_d     = val_a_q;
    diff_d      = diff_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    branch_d    = 1'b0;
    halted_d    = halted_q;
    inc         = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = FETCH_A;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_in;
        end
      end
      FETCH_A: begin
        inc = ack;
        if (ack) begin
          op_a_d     = mem_rdata;
          mem_addr_d = pc_next;
          state_d    = FETCH_B;
        end
      end
      FETCH_B: begin
        inc = ack;
        if (ack) begin
          op_b_d     = mem_rdata;
          mem_addr_d = pc_next;
          state_d    = FETCH_C;
        end
      end
      FETCH_C: begin
        inc = ack;
        if (ack) begin
          op_c_d     = mem_rdata;
          mem_addr_d = op_a_q;
          state_d    = LOAD_A;
        end
      end
      LOAD_A: begin
        if (ack) begin
          val_a_d    = mem_rdata;
          mem_addr_d = op_b_q;
          state_d    = LOAD_B;
        end
      end
      LOAD_B: begin
        if (ack) begin
          diff_d      = load_diff;
          mem_wdata_d = load_diff;
          mem_we_d    = 1'b1;
          state_d     = STORE;
        end
      end
      STORE: begin
        if (ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // Branch strobe is registered, so it is decided here and shows in UPDATE.
          branch_d  = leq & ~take_halt;
          state_d   = UPDATE;
        end
      end
      UPDATE: begin
        if (take_halt) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (run) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = branch_q ? op_c_q : pc_in;
          state_d    = FETCH_A;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign branch      = branch_q;
  assign branch_addr = op_c_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Bench for subleq_ctrl: PC block and wait-state memory models, a monitor logging
// transactions, and an instruction-level subleq reference model.
module tb_subleq_ctrl;

  logic       clk = 1'b0;
  logic       areset, run;
  logic [7:0] pc, pc_init;
  logic       branch, inc, mem_req, mem_we, mem_ack, halted;
  logic [7:0] branch_addr, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [0:255];
  logic [7:0] img [0:255];
  logic [7:0] mm  [0:255];
  int         wait_n, wcnt;
  logic       spur;

  logic [16:0] log_q[$];
  logic [16:0] exp_q[$];
  int          inc_cnt, branch_cnt, both_cnt, bad_inc, stab_err, req_cyc;
  logic [7:0]  last_baddr, p_addr, p_wdata;
  logic        pend, p_we;

  int         checks = 0, failures = 0;
  int         last_ticks;
  logic [7:0] mpc;
  int         m_taken, m_exec;
  logic       m_halt;

  always #5 clk = ~clk;

  subleq_ctrl #(.WORD_SIZE(8)) dut (
    .clk(clk), .areset(areset), .run(run), .pc_in(pc),
    .branch(branch), .inc(inc), .branch_addr(branch_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted)
  );

  assign mem_ack   = (mem_req && (wcnt == wait_n)) || (spur && !mem_req);
  assign mem_rdata = mem[mem_addr];

  // PC block and memory
  always @(posedge clk) begin
    if (areset) begin
      pc   <= pc_init;
      wcnt <= 0;
      mem  <= img;
    end else begin
      if (branch) pc <= branch_addr;
      else if (inc) pc <= pc + 8'd1;
      if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  // Mid-cycle monitor
  always @(negedge clk) begin
    if (areset) begin
      log_q.delete();
      inc_cnt <= 0; branch_cnt <= 0; both_cnt <= 0; bad_inc <= 0;
      stab_err <= 0; req_cyc <= 0; last_baddr <= 8'h00; pend <= 1'b0;
      p_addr <= 8'h00; p_wdata <= 8'h00; p_we <= 1'b0;
    end else begin
      if (mem_req && mem_ack) log_q.push_back({mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)});
      if (inc) inc_cnt <= inc_cnt + 1;
      if (branch) begin
        branch_cnt <= branch_cnt + 1;
        last_baddr <= branch_addr;
      end
      if (branch && inc) both_cnt <= both_cnt + 1;
      if (inc && !(mem_req && mem_ack)) bad_inc <= bad_inc + 1;
      if (mem_req) req_cyc <= req_cyc + 1;
      if (pend && !(mem_req && mem_addr == p_addr && mem_we == p_we && mem_wdata == p_wdata))
        stab_err <= stab_err + 1;
      pend    <= mem_req && !mem_ack;
      p_addr  <= mem_addr;
      p_we    <= mem_we;
      p_wdata <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic do_reset(input logic [7:0] pc0);
    pc_init = pc0;
    run     = 1'b0;
    areset  = 1'b1;
    tick();
    tick();
    areset  = 1'b0;
  endtask

  // Instruction-level subleq semantics on a private copy of the image.
  task automatic model_run(input int n);
    logic [7:0] a, b, c, r, p1, p2;
    mm = img;
    mpc = pc_init;
    exp_q.delete();
    m_taken = 0; m_exec = 0; m_halt = 1'b0;
    for (int k = 0; k < n && !m_halt; k++) begin
      p1 = mpc + 8'd1;
      p2 = mpc + 8'd2;
      a = mm[mpc]; b = mm[p1]; c = mm[p2];
      exp_q.push_back({1'b0, mpc, 8'h00});
      exp_q.push_back({1'b0, p1, 8'h00});
      exp_q.push_back({1'b0, p2, 8'h00});
      exp_q.push_back({1'b0, a, 8'h00});
      exp_q.push_back({1'b0, b, 8'h00});
      r = mm[b] - mm[a];
      exp_q.push_back({1'b1, b, r});
      mm[b] = r;
      m_exec++;
      mpc = mpc + 8'd3;
      if ($signed(r) <= 0) begin
        if (c == 8'hFF) m_halt = 1'b1;
        else begin
          mpc = c;
          m_taken++;
        end
      end
    end
  endtask

  // Runs n instructions (run dropped once drop_at transactions have completed).
  task automatic exec(input string tag, input int n, input int drop_at, input int wn);
    int ticks;
    wait_n = wn;
    model_run(n);
    run = 1'b1;
    ticks = 0;
    do begin
      tick();
      ticks++;
      if (log_q.size() >= drop_at) run = 1'b0;
    end while (log_q.size() < exp_q.size() && ticks < 3000);
    run = 1'b0;
    last_ticks = ticks;
    check({tag, "_timeout"}, 32'(ticks < 3000), 32'd1);
    repeat (10) tick();
    check({tag, "_ntxn"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    check({tag, "_pc"}, 32'(pc), 32'(mpc));
    check({tag, "_halted"}, 32'(halted), 32'(m_halt));
    check({tag, "_inc"}, inc_cnt, 3 * m_exec);
    check({tag, "_branch"}, branch_cnt, m_taken);
    check({tag, "_overlap"}, both_cnt + bad_inc, 0);
    check({tag, "_stable"}, stab_err, 0);
    check({tag, "_req_idle"}, 32'(mem_req), 32'd0);
    $display("txn %s: n=%0d wait=%0d txns=%0d pc=%02h halted=%0d ticks=%0d",
             tag, n, wn, log_q.size(), pc, halted, last_ticks);
  endtask

  task automatic base_prog(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] c);
    clear_img();
    img[0] = 8'd10; img[1] = 8'd11; img[2] = c;
    img[10] = va; img[11] = vb;
    img[20] = 8'd30; img[21] = 8'd31; img[22] = 8'd40;
    img[30] = 8'd1; img[31] = 8'd9;
  endtask

  initial begin
    int r0;
    wait_n = 0; spur = 1'b0; pc_init = 8'h00; run = 1'b0; areset = 1'b1;
    clear_img();
    tick(); tick();

    // Reset mid-run with wait states
    base_prog(8'd3, 8'd5, 8'd20);
    wait_n = 3;
    do_reset(8'h00);
    run = 1'b1;
    repeat (14) tick();
    check("midrun_addr", 32'(mem_addr), 32'd10);
    check("midrun_baddr", 32'(branch_addr), 32'd20);
    areset = 1'b1;
    tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_branch", 32'(branch), 32'd0);
    check("rst_inc", 32'(inc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_outs", {8'h00, mem_addr, mem_wdata, branch_addr}, 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    tick();
    run = 1'b0; areset = 1'b0; spur = 1'b1;
    repeat (5) tick();
    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_quiet", inc_cnt + log_q.size(), 0);
    spur = 1'b0;
    $display("txn reset: req=%0d halted=%0d", mem_req, halted);

    // Fall-through, zero wait
    base_prog(8'd3, 8'd5, 8'd20);
    do_reset(8'h00);
    exec("fall", 1, 999, 0);
    check("fall_cycles", last_ticks, 7);
    check("fall_write", 32'(log_q[5]), {15'd0, 1'b1, 8'd11, 8'd2});
    check("fall_pc3", 32'(pc), 32'd3);

    // Branch on zero, then continue at 20
    base_prog(8'd5, 8'd5, 8'd20);
    do_reset(8'h00);
    exec("brz", 2, 999, 0);
    check("brz_write", 32'(log_q[5]), {15'd0, 1'b1, 8'd11, 8'd0});
    check("brz_target", 32'(last_baddr), 32'd20);
    check("brz_fetch", 32'(log_q[6]), {15'd0, 1'b0, 8'd20, 8'd0});

    // Negative wrap and 0x80
    base_prog(8'd1, 8'd0, 8'd20);
    do_reset(8'h00);
    exec("neg", 1, 999, 0);
    check("neg_write", 32'(log_q[5]), {15'd0, 1'b1, 8'd11, 8'hFF});
    check("neg_taken", branch_cnt, 1);
    base_prog(8'h80, 8'h00, 8'd20);
    do_reset(8'h00);
    exec("n80", 1, 999, 0);
    check("n80_write", 32'(log_q[5]), {15'd0, 1'b1, 8'd11, 8'h80});
    check("n80_taken", branch_cnt, 1);

    // Halt convention
    base_prog(8'd5, 8'd5, 8'hFF);
    do_reset(8'h00);
    exec("halt", 1, 999, 0);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_write", 32'(log_q[5]), {15'd0, 1'b1, 8'd11, 8'd0});
    spur = 1'b1;
    r0 = req_cyc;
    run = 1'b1;
    repeat (20) tick();
    run = 1'b0;
    spur = 1'b0;
    check("halt_noreq", req_cyc, r0);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_nobranch", branch_cnt, 0);
    do_reset(8'h00);
    check("halt_cleared", 32'(halted), 32'd0);

    // Wait states, run dropped in LOAD_B, spurious acks while idle/updating
    base_prog(8'd3, 8'd5, 8'd20);
    do_reset(8'h00);
    spur = 1'b1;
    exec("wait", 1, 4, 3);
    spur = 1'b0;
    check("wait_write", 32'(log_q[5]), {15'd0, 1'b1, 8'd11, 8'd2});

    // Randomized programs
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      do_reset(8'($urandom));
      exec($sformatf("rnd%0d", it), int'($urandom_range(1, 4)), 999, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
